// File: rtl/response_encoder.sv
// Transmit-side frame serializer: takes one opcode+payload response and feeds it
// byte by byte (opcode, then payload MSB first) to the UART TX using strobe/busy.
module response_encoder #(
    parameter int PAYLOAD_BYTES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [7:0]  opcode,
    input  logic [31:0] payload,
    input  logic        tx_busy,
    output logic [7:0]  byte_out,
    output logic        byte_out_valid,
    output logic        frame_done,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    // Handshakes: a frame moves on rsp_valid && rsp_ready; a byte is offered by a
    // one-cycle byte_out_valid, acked by tx_busy rising and completed by it falling.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(PAYLOAD_BYTES);
    localparam int         PAD_BITS = 8 * (4 - PAYLOAD_BYTES);

    state_t      state;
    state_t      state_next;
    logic [39:0] sr;
    logic [2:0]  idx;
    logic        accept;
    logic        advance;

    assign rsp_ready = (state == IDLE) && !reset;
    assign accept    = rsp_valid && rsp_ready;
    assign advance   = (state == WAIT_DONE) && !tx_busy && (idx != LAST_IDX);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // byte_out is preloaded with the next byte on entry to SEND so that the
    // registered value is already correct in the strobe cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            sr       <= 40'h0;
            idx      <= 3'd0;
            byte_out <= 8'h00;
        end else begin
            state <= state_next;
            if (accept) begin
                sr       <= {opcode, payload << PAD_BITS};
                idx      <= 3'd0;
                byte_out <= opcode;
            end else if (advance) begin
                sr       <= sr << 8;
                idx      <= idx + 3'd1;
                byte_out <= sr[31:24];
            end
        end
    end

    always_comb begin
        state_next     = state;
        byte_out_valid = 1'b0;
        frame_done     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    byte_out_valid = 1'b1;
                    state_next     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) state_next = (idx == LAST_IDX) ? DONE : SEND;
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/response_encoder.md
# response_encoder

Frame serializer for the host link's transmit direction, the counterpart of the command decoder on the receive side. It accepts one response frame (8-bit opcode plus up to 32-bit payload) and emits it byte by byte to the UART transmitter: opcode first, then payload most-significant byte first. Each byte uses a strobe/busy handshake. The block sits between the capture/control logic that produces responses and the UART TX.

## Interface
Parameters:
- PAYLOAD_BYTES, 4, number of payload bytes sent after the opcode. Legal range is 1..4. Sent bytes are payload[8*PAYLOAD_BYTES-1:0], MSB byte first.

Ports:
- clock  in  1  single clock; all logic is on its rising edge
- reset  in  1  synchronous, active-high reset
- rsp_valid  in  1  producer has a frame on opcode/payload
- rsp_ready  out  1  encoder can accept a frame; high only in IDLE
- opcode  in  8  frame opcode; sampled on accept
- payload  in  32  frame payload; sampled on accept
- tx_busy  in  1  UART TX is shifting a byte
- byte_out  out  8  byte presented to the UART TX; registered
- byte_out_valid  out  1  one-cycle start strobe for byte_out
- frame_done  out  1  one-cycle pulse after the last byte finishes
- busy  out  1  high in every state except IDLE

## Operation
- Frame store: 40-bit shift register sr and a 3-bit byte counter idx.
- Accept: when rsp_valid && rsp_ready, sr <= {opcode, payload << 8*(4-PAYLOAD_BYTES)}, idx <= 0, state goes to SEND.
- Inputs are ignored after accept. Changing opcode or payload mid-frame has no effect.
- State machine:
  - IDLE: rsp_ready=1. On accept, go to SEND.
  - SEND: if tx_busy=0, assert byte_out_valid=1, set byte_out <= sr[39:32], go to WAIT_ACK. If tx_busy=1, stay in SEND with no strobe.
  - WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_busy=0. Then, if idx==PAYLOAD_BYTES, go to DONE. Otherwise sr <= sr<<8, idx <= idx+1, go to SEND.
  - DONE: frame_done=1 for one cycle, then go to IDLE.
  - Any unused encoding goes to IDLE.
- Byte count per frame is exactly 1+PAYLOAD_BYTES strobes.
- byte_out holds its last value between strobes. It is valid only in the cycle byte_out_valid=1 and is stable until the next strobe.

## Timing
- Reset values: rsp_ready=0 during reset, then 1 in IDLE from the first cycle after reset. byte_out=8'h00, byte_out_valid=0, frame_done=0, busy=0, state=IDLE, idx=0, sr=0.
- Accept edge is cycle 0. The first strobe is at cycle 1 if tx_busy=0.
- Strobe spacing with a TX that raises busy 1 cycle after the strobe and holds it for B cycles: strobe at t, busy high t+1..t+B, next strobe at t+B+2.
- frame_done is asserted 1 cycle after tx_busy falls following the last byte. rsp_ready rises the next cycle.
- Back-to-back frames: if rsp_valid is held high, the next accept occurs in the IDLE cycle following DONE. There is no combinational path from rsp_valid to rsp_ready.
- tx_busy already high on entry to SEND: no strobe is issued until it is low. A busy pulse belonging to a previous transfer is never mistaken for an ack, because WAIT_ACK is entered only after our strobe.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. No further strobes are issued and the partial frame is dropped (the host resynchronizes via the frame length).
- rsp_valid while busy=1: the frame is not accepted. The producer must hold it until rsp_ready.

## Test plan
- PAYLOAD_BYTES=4, opcode=8'hA5, payload=32'h12345678, TX model with busy 1 cycle after strobe, B=10 -> strobes carry A5,12,34,56,78 in order, spacing 12 cycles, single frame_done after the 5th byte, rsp_ready low throughout.
- PAYLOAD_BYTES=2, payload=32'hDEADBEEF, opcode=8'h01 -> bytes 01,BE,EF only; exactly 3 strobes.
- tx_busy held high for 20 cycles before and across accept -> no strobe until busy drops; first strobe the cycle after busy goes low; byte order unchanged.
- rsp_valid held high with two frames (11/AABBCCDD then 22/00000001) -> 10 strobes 11,AA,BB,CC,DD,22,00,00,00,01; second accept in the IDLE cycle after the first frame_done.
- Reset asserted in WAIT_DONE of byte 2 -> next cycle busy=0, rsp_ready=1, byte_out=00. No strobe occurs even after tx_busy falls. A new frame then sends correctly from its opcode.
- Change opcode/payload every cycle after accept -> transmitted bytes match the values sampled at accept.
